// File: rtl/frame_fifo_pkg.sv
// rtl/frame_fifo_pkg.sv - shared types, widths and pointer helper for frame_fifo
package frame_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DISCARD
    } wr_state_t;

    localparam int DROP_CNT_W = 16;
    localparam int PTR_MAX_W  = 16;

    // Modular difference a - b, truncated to w bits (pointer width is AW+1).
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(
        input logic [PTR_MAX_W-1:0] a,
        input logic [PTR_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [PTR_MAX_W-1:0] mask;
        mask = (PTR_MAX_W'(1) << w) - PTR_MAX_W'(1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/frame_fifo_mem.sv
// rtl/frame_fifo_mem.sv - simple dual-port RAM, registered read, last-bit peek
module frame_fifo_mem
    import frame_fifo_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_q,
    output logic          peek_last
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value on cycles without a read.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Frame counter needs the last flag of the entry being accepted this cycle.
    assign peek_last = mem[rd_addr][W-1];

endmodule

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - frame FIFO with commit/rewind; FRAME_FIFO_DROP_CNT_EN adds drop_cnt
module frame_fifo
    import frame_fifo_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              wr_drop,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_valid,
    output logic              empty,
    output logic [AW:0]       frame_cnt,
    output logic [AW:0]       wr_level
`ifdef FRAME_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] rd_ptr;
    wr_state_t   state;

    logic mem_we;
    logic overflow;
    logic commit;
    logic rd_accept;
    logic peek_last;
    logic last_read;

    assign wr_level = (AW+1)'(ptr_diff(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr), AW+1));
    assign full     = (wr_level == DEPTH_L);
    assign empty    = (rd_ptr == commit_ptr);

    // wr_drop outranks wr_en; a full FIFO turns the beat into an overflow.
    assign mem_we    = wr_en && !wr_drop && !full && (state != DISCARD);
    assign overflow  = wr_en && !wr_drop && full && (state != DISCARD);
    assign commit    = mem_we && wr_last;
    assign rd_accept = rd_en && !empty;
    assign last_read = rd_accept && peek_last;

    frame_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .arst      (arst),
        .we        (mem_we),
        .wr_addr   (wr_ptr[AW-1:0]),
        .wr_data   ({wr_last, wr_data}),
        .re        (rd_accept),
        .rd_addr   (rd_ptr[AW-1:0]),
        .rd_q      ({rd_last, rd_data}),
        .peek_last (peek_last)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            frame_cnt  <= '0;
            rd_valid   <= 1'b0;
            state      <= IDLE;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (commit && !last_read) begin
                frame_cnt <= frame_cnt + 1'b1;
            end else if (last_read && !commit) begin
                frame_cnt <= frame_cnt - 1'b1;
            end

            if (wr_drop) begin
                wr_ptr <= commit_ptr;
                state  <= IDLE;
            end else if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_last) begin
                    commit_ptr <= wr_ptr + 1'b1;
                    state      <= IDLE;
                end else begin
                    state <= ACTIVE;
                end
            end else if (overflow) begin
                wr_ptr <= commit_ptr;
                state  <= wr_last ? IDLE : DISCARD;
            end else if (state == DISCARD && wr_en && wr_last) begin
                state <= IDLE;
            end
        end
    end

`ifdef FRAME_FIFO_DROP_CNT_EN
    // A drop while already discarding belongs to the same rewound frame.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            drop_cnt <= '0;
        end else if ((overflow || (wr_drop && state != DISCARD)) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_fifo.sv
// tb/tb_frame_fifo.sv - directed self-checking bench for frame_fifo
module tb_frame_fifo;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       wr_drop = 1'b0;
    logic       full;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_valid;
    logic       empty;
    logic [4:0] frame_cnt;
    logic [4:0] wr_level;
`ifdef FRAME_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    frame_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk       (clk),
        .arst      (arst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_drop   (wr_drop),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .frame_cnt (frame_cnt),
        .wr_level  (wr_level)
`ifdef FRAME_FIFO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic wr_beat(input logic [7:0] d, input logic l);
        wr_en = 1'b1;
        wr_data = d;
        wr_last = l;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b want 1", empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full); else passed++;
        total++; if (frame_cnt !== 5'd0) $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); else passed++;
        total++; if (wr_level !== 5'd0) $display("FAIL rst_wr_level got %0d want 0", wr_level); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %b want 0", rd_valid); else passed++;
        total++; if ({rd_last, rd_data} !== 9'h000) $display("FAIL rst_rd_data got %h want 000", {rd_last, rd_data}); else passed++;
        @(negedge clk) arst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] exp3 [3];
        exp3 = '{8'h11, 8'h22, 8'h33};
        wr_beat(8'h11, 1'b0);
        wr_beat(8'h22, 1'b0);
        wr_beat(8'h33, 1'b1);
        total++; if (frame_cnt !== 5'd1) $display("FAIL basic_cnt1 got %0d want 1", frame_cnt); else passed++;
        total++; if (empty !== 1'b0) $display("FAIL basic_nonempty got %b want 0", empty); else passed++;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (rd_valid !== 1'b1) $display("FAIL basic_valid[%0d] got %b want 1", i, rd_valid); else passed++;
            total++; if (rd_data !== exp3[i]) $display("FAIL basic_data[%0d] got %h want %h", i, rd_data, exp3[i]); else passed++;
            total++; if (rd_last !== (i == 2)) $display("FAIL basic_last[%0d] got %b want %b", i, rd_last, (i == 2)); else passed++;
            if (i == 2) rd_en = 1'b0;
        end
        total++; if (frame_cnt !== 5'd0) $display("FAIL basic_cnt0 got %0d want 0", frame_cnt); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL basic_empty got %b want 1", empty); else passed++;
        @(posedge clk); #1;
        total++; if (rd_valid !== 1'b0) $display("FAIL basic_valid_off got %b want 0", rd_valid); else passed++;
        total++; if (rd_data !== 8'h33) $display("FAIL basic_hold got %h want 33", rd_data); else passed++;
    endtask

    task automatic test_no_commit();
        rd_en = 1'b1;
        wr_beat(8'hC1, 1'b0);
        total++; if (empty !== 1'b1) $display("FAIL nc_empty0 got %b want 1", empty); else passed++;
        wr_beat(8'hC2, 1'b0);
        total++; if (empty !== 1'b1) $display("FAIL nc_empty1 got %b want 1", empty); else passed++;
        total++; if (wr_level !== 5'd2) $display("FAIL nc_level got %0d want 2", wr_level); else passed++;
        @(posedge clk); #1;
        total++; if (rd_valid !== 1'b0) $display("FAIL nc_valid got %b want 0", rd_valid); else passed++;
        rd_en = 1'b0;
        wr_drop = 1'b1;
        @(posedge clk); #1;
        wr_drop = 1'b0;
        total++; if (wr_level !== 5'd0) $display("FAIL nc_drop_level got %0d want 0", wr_level); else passed++;
        total++; if (frame_cnt !== 5'd0) $display("FAIL nc_frame_cnt got %0d want 0", frame_cnt); else passed++;
`ifdef FRAME_FIFO_DROP_CNT_EN
        total++; if (drop_cnt !== 16'd1) $display("FAIL nc_drop_cnt got %0d want 1", drop_cnt); else passed++;
`endif
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) wr_beat(8'(8'h40 + i), (i == 9));
        total++; if (wr_level !== 5'd10) $display("FAIL ovf_level1 got %0d want 10", wr_level); else passed++;
        for (int i = 0; i < 10; i++) begin
            wr_beat(8'(8'h80 + i), (i == 9));
            if (i == 5) begin
                total++; if (full !== 1'b1) $display("FAIL ovf_full got %b want 1", full); else passed++;
                total++; if (wr_level !== 5'd16) $display("FAIL ovf_level16 got %0d want 16", wr_level); else passed++;
            end
            if (i == 6) begin
                total++; if (wr_level !== 5'd10) $display("FAIL ovf_rewind got %0d want 10", wr_level); else passed++;
                total++; if (full !== 1'b0) $display("FAIL ovf_notfull got %b want 0", full); else passed++;
            end
        end
        total++; if (wr_level !== 5'd10) $display("FAIL ovf_level_end got %0d want 10", wr_level); else passed++;
        total++; if (frame_cnt !== 5'd1) $display("FAIL ovf_frame_cnt got %0d want 1", frame_cnt); else passed++;
`ifdef FRAME_FIFO_DROP_CNT_EN
        total++; if (drop_cnt !== 16'd2) $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); else passed++;
`endif
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (rd_data !== 8'(8'h40 + i)) $display("FAIL ovf_data[%0d] got %h want %h", i, rd_data, 8'(8'h40 + i)); else passed++;
            total++; if (rd_last !== (i == 9)) $display("FAIL ovf_last[%0d] got %b want %b", i, rd_last, (i == 9)); else passed++;
            if (i == 9) rd_en = 1'b0;
        end
        total++; if (empty !== 1'b1) $display("FAIL ovf_empty got %b want 1", empty); else passed++;
        total++; if (wr_level !== 5'd0) $display("FAIL ovf_level0 got %0d want 0", wr_level); else passed++;
    endtask

    task automatic test_oversize();
        for (int i = 0; i < 20; i++) wr_beat(8'(8'hA0 + i), (i == 19));
        total++; if (wr_level !== 5'd0) $display("FAIL big_level got %0d want 0", wr_level); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL big_empty got %b want 1", empty); else passed++;
`ifdef FRAME_FIFO_DROP_CNT_EN
        total++; if (drop_cnt !== 16'd3) $display("FAIL big_drop_cnt got %0d want 3", drop_cnt); else passed++;
`endif
        wr_beat(8'h5A, 1'b0);
        wr_beat(8'h5B, 1'b1);
        total++; if (frame_cnt !== 5'd1) $display("FAIL big_next_cnt got %0d want 1", frame_cnt); else passed++;
        rd_en = 1'b1;
        @(posedge clk); #1;
        total++; if ({rd_last, rd_data} !== 9'h05A) $display("FAIL big_rd0 got %h want 05a", {rd_last, rd_data}); else passed++;
        rd_en = 1'b0;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        total++; if ({rd_last, rd_data} !== 9'h15B) $display("FAIL big_rd1 got %h want 15b", {rd_last, rd_data}); else passed++;
        total++; if (frame_cnt !== 5'd0) $display("FAIL big_cnt0 got %0d want 0", frame_cnt); else passed++;
    endtask

    task automatic test_wrap();
        int j;
        j = 0;
        rd_en = 1'b1;
        for (int i = 0; i < 44; i++) begin
            wr_en = (i < 40);
            wr_last = (i < 40);
            wr_data = 8'(i);
            @(posedge clk); #1;
            total++; if (full !== 1'b0) $display("FAIL wrap_full[%0d] got %b want 0", i, full); else passed++;
            total++; if (frame_cnt > 5'd16) $display("FAIL wrap_cnt[%0d] got %0d want <=16", i, frame_cnt); else passed++;
            if (rd_valid) begin
                total++; if ({rd_last, rd_data} !== {1'b1, 8'(j)}) $display("FAIL wrap_data[%0d] got %h want %h", j, {rd_last, rd_data}, {1'b1, 8'(j)}); else passed++;
                j++;
            end
        end
        wr_en = 1'b0;
        wr_last = 1'b0;
        rd_en = 1'b0;
        total++; if (j !== 40) $display("FAIL wrap_count got %0d want 40", j); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty); else passed++;
        total++; if (frame_cnt !== 5'd0) $display("FAIL wrap_cnt_end got %0d want 0", frame_cnt); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 5; i++) wr_beat(8'(i), (i == 5));
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        total++; if (rd_data !== 8'h01) $display("FAIL ar_pre_data got %h want 01", rd_data); else passed++;
        wr_beat(8'hE0, 1'b0);
        total++; if (frame_cnt !== 5'd1) $display("FAIL ar_pre_cnt got %0d want 1", frame_cnt); else passed++;
        wr_en = 1'b1;
        wr_data = 8'hE1;
        #2 arst = 1'b1;
        #1;
        total++; if (empty !== 1'b1) $display("FAIL ar_empty got %b want 1", empty); else passed++;
        total++; if (frame_cnt !== 5'd0) $display("FAIL ar_cnt got %0d want 0", frame_cnt); else passed++;
        total++; if (wr_level !== 5'd0) $display("FAIL ar_level got %0d want 0", wr_level); else passed++;
        total++; if ({rd_valid, rd_last, rd_data} !== 10'h000) $display("FAIL ar_rd got %h want 000", {rd_valid, rd_last, rd_data}); else passed++;
`ifdef FRAME_FIFO_DROP_CNT_EN
        total++; if (drop_cnt !== 16'd0) $display("FAIL ar_drop_cnt got %0d want 0", drop_cnt); else passed++;
`endif
        wr_en = 1'b0;
        @(negedge clk) arst = 1'b0;
        @(posedge clk); #1;
        wr_beat(8'h77, 1'b1);
        total++; if (frame_cnt !== 5'd1) $display("FAIL ar_post_cnt got %0d want 1", frame_cnt); else passed++;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        total++; if ({rd_valid, rd_last, rd_data} !== 10'h377) $display("FAIL ar_post_rd got %h want 377", {rd_valid, rd_last, rd_data}); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL ar_post_empty got %b want 1", empty); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_commit();
        test_overflow();
        test_oversize();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frame_fifo.md
Name: frame_fifo

Overview:
- Single-clock, parametrised frame FIFO for the MAC receive/transmit datapaths.
- Data width is independent of depth.
- Frames are written beat by beat, marked by wr_last, and become readable only once committed.
- Frames that overflow, or that are explicitly dropped (e.g. bad FCS), are rewound and never reach the reader.

Parameters:
DATA_W, 8, data beat width in bits
DEPTH, 16, entries; power of two, >= 4
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  input  1  clock
arst  input  1  asynchronous active-high reset
wr_en  input  1  write beat strobe
wr_data  input  DATA_W  write beat data
wr_last  input  1  final beat of frame, qualified by wr_en
wr_drop  input  1  single-cycle pulse: discard frame in progress
full  output  1  wr_level == DEPTH
rd_en  input  1  read request
rd_data  output  DATA_W  read data, registered
rd_last  output  1  last-beat flag for rd_data
rd_valid  output  1  rd_data/rd_last valid this cycle
empty  output  1  no committed beat unread (rd_ptr == commit_ptr)
frame_cnt  output  AW+1  committed frames not yet fully read
wr_level  output  AW+1  wr_ptr - rd_ptr (occupied entries, including uncommitted)

Behaviour:
- Interface: one clock, clk. Reset arst is asynchronous and active-high.
- Reset:
  - wr_ptr, commit_ptr, rd_ptr, frame_cnt, rd_valid, rd_data, rd_last are 0.
  - empty=1, full=0, state=IDLE.
  - Reset asserted mid-frame or mid-read discards everything immediately.
- Pointers are AW+1 bits wide and wrap modulo 2*DEPTH. Memory stores {last, data}, DATA_W+1 bits.
- Write FSM states: IDLE (no frame open), ACTIVE (frame partially written), DISCARD (overflowed; dropping until wr_last).
- IDLE/ACTIVE, wr_en && !full:
  - Write mem[wr_ptr] and increment wr_ptr.
  - If wr_last: commit_ptr <= wr_ptr+1, frame_cnt increments, next state IDLE.
  - Otherwise: next state ACTIVE.
- IDLE/ACTIVE, wr_en && full:
  - Beat is discarded and wr_ptr <= commit_ptr (rewind).
  - If wr_last: next state IDLE, else DISCARD.
  - An oversized frame (> DEPTH beats) therefore self-drops, so no deadlock.
- DISCARD:
  - All beats are ignored and no pointer moves.
  - wr_en && wr_last -> IDLE.
- wr_drop, any state:
  - Takes priority over wr_en in the same cycle; that beat is discarded.
  - wr_ptr <= commit_ptr, next state IDLE.
- Read (latency 1):
  - rd_en && !empty: rd_data/rd_last <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 the next cycle.
  - Otherwise rd_valid=0 next cycle, with rd_data/rd_last holding their previous values.
  - rd_en while empty is ignored.
- frame_cnt:
  - Decrements on an accepted read whose stored last bit is 1.
  - A simultaneous commit and last-read leaves it unchanged.
- Status flags:
  - full and empty are combinational from registered pointers.
  - A commit at edge N clears empty after edge N, so the earliest rd_en is in cycle N+1 and data appears in cycle N+2.
- The reader never observes uncommitted beats. A rewind never crosses rd_ptr because commit_ptr lies between rd_ptr and wr_ptr.
- Simultaneous write and read when full: the read frees space only from the next cycle; the write that cycle is still treated as overflow.

Optional Feature:
- Macro: FRAME_FIFO_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt (16 bits), a saturating count of dropped frames.
  - Increments once per entry into rewind, whether from overflow or wr_drop.
  - A wr_drop while already in DISCARD is not double-counted.
  - Reset value is 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package frame_fifo_pkg:
  - wr_state_t enum {IDLE, ACTIVE, DISCARD}.
  - DROP_CNT_W = 16.
  - Function ptr_diff(a, b) returning AW+1-bit modular difference.
- Sub-module frame_fifo_mem:
  - Simple dual-port RAM, one write port and one registered read port.
  - Width DATA_W+1, depth DEPTH, no reset on the array.
  - Top holds the FSM, pointers and counters.

Test Plan:
- Write a 3-beat frame 0x11,0x22,0x33 (last on 0x33), then read 3 times -> rd_data 0x11,0x22,0x33 in consecutive cycles; rd_last only on 0x33; frame_cnt 1->0; empty=1 afterwards.
- Write 2 beats without last and hold rd_en high -> empty stays 1 and rd_valid stays 0. Then pulse wr_drop -> wr_level returns to 0 and drop_cnt=1 if enabled.
- DEPTH=16: commit a 10-beat frame, then start a 10-beat frame -> full at the 6th beat, the 7th beat triggers rewind, wr_level=10, frame 2 is never read, and frame 1 reads intact.
- Write a 20-beat frame into an empty FIFO (DEPTH=16) -> frame dropped, FSM returns to IDLE at wr_last, and a following 2-beat frame commits and reads correctly.
- Wrap-around: stream 40 single-beat frames with concurrent reads -> data order preserved, frame_cnt never exceeds 16, and no spurious full/empty.
- Assert arst mid-frame with 5 committed beats -> all outputs return to reset values immediately (asynchronously); the first frame after release reads correctly.
